// File: rtl/smoothing_filter_3x3_pkg.sv
// rtl/smoothing_filter_3x3_pkg.sv - kernel modes, coefficients and rounding constants for the 3x3 smoothing stage
package smoothing_filter_3x3_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GAUSS  = 2'd1,
    MODE_HORIZ  = 2'd2,
    MODE_VERT   = 2'd3
  } mode_e;

  // Headroom above DATA_WIDTH so the 16x-weighted Gaussian sum plus rounding never wraps.
  localparam int ACC_GUARD_BITS = 4;

  localparam int GAUSS_CORNER = 1;
  localparam int GAUSS_EDGE   = 2;
  localparam int GAUSS_CENTRE = 4;
  localparam int GAUSS_ROUND  = 8;
  localparam int GAUSS_SHIFT  = 4;

  localparam int LINE_SIDE    = 1;
  localparam int LINE_CENTRE  = 2;
  localparam int LINE_ROUND   = 2;
  localparam int LINE_SHIFT   = 2;

  function automatic int acc_width(input int data_width);
    return data_width + ACC_GUARD_BITS;
  endfunction

endpackage

// File: rtl/smoothing_filter_3x3_if.sv
// rtl/smoothing_filter_3x3_if.sv - pixel-in / filtered-pixel-out handshake bundle
interface smoothing_filter_3x3_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] pixel;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] filtered_pixel;
  logic                  out_sof;
  logic                  out_eol;

  modport master (
    output in_valid,
    output pixel,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  filtered_pixel,
    input  out_sof,
    input  out_eol
  );

  modport slave (
    input  in_valid,
    input  pixel,
    output in_ready,
    output out_valid,
    input  out_ready,
    output filtered_pixel,
    output out_sof,
    output out_eol
  );

endinterface

// File: rtl/smoothing_filter_3x3_window_buffer.sv
// rtl/smoothing_filter_3x3_window_buffer.sv - two line RAMs plus column history forming the 3x3 window
module smoothing_filter_3x3_window_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_WIDTH = 640,
  parameter int COL_W       = $clog2(IMAGE_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift_en,
  input  logic [COL_W-1:0]                 col,
  input  logic [DATA_WIDTH-1:0]            pixel,
  output logic [2:0][2:0][DATA_WIDTH-1:0]  window
);

  logic [DATA_WIDTH-1:0] line_top [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] line_mid [IMAGE_WIDTH];

  logic [2:0][DATA_WIDTH-1:0]      new_col;
  logic [2:0][1:0][DATA_WIDTH-1:0] hist_q;

  // The incoming column completes the window combinationally so the kernel sees it on the accept cycle.
  always_comb begin
    new_col[0] = line_top[col];
    new_col[1] = line_mid[col];
    new_col[2] = pixel;
    for (int r = 0; r < 3; r++) begin
      window[r][0] = hist_q[r][0];
      window[r][1] = hist_q[r][1];
      window[r][2] = new_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      line_top[col] <= new_col[1];
      line_mid[col] <= pixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= hist_q[r][1];
        hist_q[r][1] <= new_col[r];
      end
    end
  end

endmodule

// File: rtl/smoothing_filter_3x3.sv
// rtl/smoothing_filter_3x3.sv - streaming 3x3 smoothing with run-time kernel selection
module smoothing_filter_3x3
  import smoothing_filter_3x3_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  smoothing_filter_3x3_if.slave    stream,
  input  logic [1:0]               mode,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int ACC_W = acc_width(DATA_WIDTH);

  localparam logic [ACC_W-1:0] K_CORNER = ACC_W'(GAUSS_CORNER);
  localparam logic [ACC_W-1:0] K_EDGE   = ACC_W'(GAUSS_EDGE);
  localparam logic [ACC_W-1:0] K_CENTRE = ACC_W'(GAUSS_CENTRE);
  localparam logic [ACC_W-1:0] K_SIDE   = ACC_W'(LINE_SIDE);
  localparam logic [ACC_W-1:0] K_MID    = ACC_W'(LINE_CENTRE);
  localparam logic [ACC_W-1:0] G_ROUND  = ACC_W'(GAUSS_ROUND);
  localparam logic [ACC_W-1:0] L_ROUND  = ACC_W'(LINE_ROUND);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  mode_e            mode_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] filtered_q;
  logic                  out_sof_q;
  logic                  out_eol_q;
  logic                  frame_done_q;

  logic advance;
  logic accept;
  logic last_col;
  logic last_row;
  logic interior;
  logic frame_start;

  logic [2:0][2:0][DATA_WIDTH-1:0] win;
  logic [ACC_W-1:0]                gauss_acc;
  logic [ACC_W-1:0]                horiz_acc;
  logic [ACC_W-1:0]                vert_acc;
  logic [DATA_WIDTH-1:0]           kernel_out;

  assign advance     = !out_valid_q || stream.out_ready;
  assign accept      = stream.in_valid && advance;
  assign last_col    = (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign last_row    = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign interior    = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign frame_start = (row_q == '0) && (col_q == '0);

  assign stream.in_ready       = advance;
  assign stream.out_valid      = out_valid_q;
  assign stream.filtered_pixel = filtered_q;
  assign stream.out_sof        = out_sof_q;
  assign stream.out_eol        = out_eol_q;
  assign frame_done            = frame_done_q;

  smoothing_filter_3x3_window_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .COL_W       (COL_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .col      (col_q),
    .pixel    (stream.pixel),
    .window   (win)
  );

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return ACC_W'(p);
  endfunction

  // win[row][col]: row 0 is the oldest line, col 0 the oldest column; win[1][1] is the centre.
  always_comb begin
    gauss_acc = ext(win[0][0]) * K_CORNER + ext(win[0][1]) * K_EDGE   + ext(win[0][2]) * K_CORNER
              + ext(win[1][0]) * K_EDGE   + ext(win[1][1]) * K_CENTRE + ext(win[1][2]) * K_EDGE
              + ext(win[2][0]) * K_CORNER + ext(win[2][1]) * K_EDGE   + ext(win[2][2]) * K_CORNER
              + G_ROUND;
    horiz_acc = ext(win[1][0]) * K_SIDE + ext(win[1][1]) * K_MID + ext(win[1][2]) * K_SIDE + L_ROUND;
    vert_acc  = ext(win[0][1]) * K_SIDE + ext(win[1][1]) * K_MID + ext(win[2][1]) * K_SIDE + L_ROUND;

    kernel_out = win[1][1];
    case (mode_q)
      MODE_GAUSS: kernel_out = DATA_WIDTH'(gauss_acc >> GAUSS_SHIFT);
      MODE_HORIZ: kernel_out = DATA_WIDTH'(horiz_acc >> LINE_SHIFT);
      MODE_VERT:  kernel_out = DATA_WIDTH'(vert_acc >> LINE_SHIFT);
      default:    kernel_out = win[1][1];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= MODE_BYPASS;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && last_col && last_row;
      if (accept) begin
        if (frame_start) begin
          mode_q <= mode_e'(mode);
        end
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Border windows, including those wrapping across a line end, retire the slot without emitting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      filtered_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= accept && interior;
      out_sof_q   <= accept && interior && (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
      out_eol_q   <= accept && interior && last_col;
      if (accept && interior) begin
        filtered_q <= kernel_out;
      end
    end
  end

endmodule
